// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: single-outstanding burst memory target for the D-cache read/write channels
module dcache_mem_responder #(
   parameter logic [31:0] BASE   = 32'h8000_0000,
   parameter int          DEPTH  = 4096,
   parameter int          RD_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r_valid_i,
   input  logic [31:0] r_addr_i,
   input  logic [7:0]  r_len_i,
   output logic        r_ready_o,
   output logic        r_last_o,
   output logic [63:0] r_data_o,
   input  logic        w_valid_i,
   input  logic [31:0] w_addr_i,
   input  logic [7:0]  w_len_i,
   input  logic [2:0]  w_size_i,
   input  logic [63:0] w_data_i,
   output logic        w_ready_o,
   output logic        w_last_o,
   output logic [31:0] err_cnt_o
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BEAT, WR_BEAT} state_t;
   state_t state, state_nx;
   logic [31:0] addr, off;
   logic [7:0] len, len_nx, cnt, cnt_nx, lsb_mask, be;
   logic [2:0] size;
   logic [3:0] lat, nb;
   logic [63:0] mem [DEPTH];
   logic [63:0] wdat;
   logic [AW-1:0] idx;
   logic in_rng, hs, acc_w, acc_r;
   assign off = addr + {21'd0, cnt, 3'd0} - BASE;
   assign in_rng = (off >> 3) < 32'(DEPTH);
   assign idx = off[AW+2:3];
   assign hs = state == WR_BEAT && w_valid_i && w_ready_o;
   // r_last_o high means the read finished this cycle; its held request must not be re-accepted
   assign acc_w = state == IDLE && !r_last_o && w_valid_i;
   assign acc_r = state == IDLE && !r_last_o && !w_valid_i && r_valid_i;
   assign len_nx = acc_w ? w_len_i : acc_r ? r_len_i : len;
   assign cnt_nx = (acc_w || acc_r) ? 8'd0 : (state == RD_BEAT || hs) ? cnt + 8'd1 : cnt;
   assign nb = 4'd1 << (size > 3'd3 ? 2'd3 : size[1:0]);
   assign lsb_mask = 8'((9'd1 << nb) - 9'd1);
   assign be = len == 8'd0 ? lsb_mask << addr[2:0] : 8'hff;
   assign wdat = len == 8'd0 ? w_data_i << {addr[2:0], 3'b000} : w_data_i;
   // state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;
   // next-state: writes win over reads in IDLE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = acc_w ? WR_BEAT : !acc_r ? IDLE : RD_LAT == 0 ? RD_BEAT : RD_WAIT;
         RD_WAIT: state_nx = lat == 4'd1 ? RD_BEAT : RD_WAIT;
         RD_BEAT: state_nx = cnt == len ? IDLE : RD_BEAT;
         WR_BEAT: state_nx = hs && cnt == len ? IDLE : WR_BEAT;
         default: state_nx = IDLE;
      endcase
   end
   // registered outputs, request latches, beat/latency counters and error count
   always_ff @(posedge clk)
      if (rst) begin
         r_ready_o <= 1'b0;
         r_last_o  <= 1'b0;
         r_data_o  <= 64'd0;
         w_ready_o <= 1'b0;
         w_last_o  <= 1'b0;
         err_cnt_o <= 32'd0;
         cnt       <= 8'd0;
         lat       <= 4'd0;
         len       <= 8'd0;
         addr      <= 32'd0;
         size      <= 3'd0;
      end else begin
         r_ready_o <= state == RD_BEAT;
         r_last_o  <= state == RD_BEAT && cnt == len;
         r_data_o  <= (state == RD_BEAT && in_rng) ? mem[idx] : 64'd0;
         w_ready_o <= state_nx == WR_BEAT;
         w_last_o  <= state_nx == WR_BEAT && cnt_nx == len_nx;
         err_cnt_o <= err_cnt_o + 32'((state == RD_BEAT || hs) && !in_rng);
         cnt       <= cnt_nx;
         lat       <= acc_r ? 4'(RD_LAT) : state == RD_WAIT ? lat - 4'd1 : lat;
         len       <= len_nx;
         addr      <= acc_w ? w_addr_i : acc_r ? r_addr_i : addr;
         size      <= acc_w ? w_size_i : size;
      end
   // backing store: byte-enabled commit of in-range write beats, never cleared
   always_ff @(posedge clk)
      if (!rst && hs && in_rng)
         for (int b = 0; b < 8; b++)
            if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
endmodule

// File: doc/dcache_mem_responder.md
# dcache_mem_responder

Memory-side responder for the simplified AXI-style read/write channels driven by the data cache (refill, dirty write-back, uncached device access). It accepts one transaction at a time, serves incrementing bursts of 64-bit beats, and backs them with an internal word-addressed memory. It sits between the D-cache and simulation/SoC memory, and is the reference target for cache verification.

## Interface
- BASE, 32'h8000_0000, byte address of word 0
- DEPTH, 4096, number of 64-bit words; power of two
- RD_LAT, 2, idle cycles between read acceptance and first beat; legal 0..15
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- r_valid_i  in  1  read request; held high, with addr/len stable, until the cycle after the last beat
- r_addr_i  in  32  read byte address
- r_len_i  in  8  beats minus one
- r_ready_o  out  1  read beat valid on r_data_o this cycle
- r_last_o  out  1  final read beat, asserted with r_ready_o
- r_data_o  out  64  read data
- w_valid_i  in  1  write request/beat valid; addr/len/size stable for the whole burst
- w_addr_i  in  32  write byte address
- w_len_i  in  8  beats minus one
- w_size_i  in  3  log2 bytes for single-beat writes; 4..7 treated as 3
- w_data_i  in  64  write data; initiator advances it the cycle after each w_valid_i & w_ready_o
- w_ready_o  out  1  beat accepted this cycle
- w_last_o  out  1  final write beat accepted, asserted with w_ready_o
- err_cnt_o  out  32  count of out-of-range beats, wraps

## Operation
- FSM states: IDLE, RD_WAIT, RD_BEAT, WR_BEAT.
- IDLE: w_valid_i has priority over r_valid_i. On w_valid_i, latch addr/len/size and go to WR_BEAT. Otherwise, on r_valid_i, latch addr/len and go to RD_WAIT, or directly to RD_BEAT when RD_LAT=0. A read kept pending by a write is served after the write returns to IDLE.
- RD_WAIT: decrement the latency counter; enter RD_BEAT after RD_LAT cycles in RD_WAIT.
- RD_BEAT: one beat per cycle, no stalls. Beat k returns word ((addr-BASE)>>3)+k. addr[2:0] is ignored; the whole aligned word is returned. r_last_o is high on beat k=len. Go to IDLE after the last beat.
- WR_BEAT: w_ready_o is high every cycle while in WR_BEAT. A beat commits only when w_valid_i & w_ready_o; if w_valid_i drops, the beat counter holds. On the handshake of beat len, assert w_last_o and go to IDLE.
- Write masking, len=0: write 2^size bytes. w_data_i is LSB-justified; byte i goes to byte lane addr[2:0]+i. Bytes falling past lane 7 are dropped. Other lanes keep their old value.
- Write masking, len>0: size and addr[2:0] are ignored; all 8 lanes are written for every beat.
- Range check, per beat: a beat is in range when its byte address minus BASE (32-bit unsigned) is < DEPTH*8. An out-of-range read beat returns 64'h0. An out-of-range write beat is dropped. Each out-of-range beat increments err_cnt_o by 1.
- The beat address increments by 8 bytes per beat. It never wraps inside the memory; a burst crossing the top goes out of range.
- Memory contents are not cleared by reset.

## Timing
- All outputs are registered.
- Reset values: r_ready_o=0, r_last_o=0, r_data_o=0, w_ready_o=0, w_last_o=0, err_cnt_o=0; FSM=IDLE.
- Read: r_valid_i sampled in IDLE at edge T produces beat 0 at cycle T+RD_LAT+1; beat k at T+RD_LAT+1+k. After the last beat, r_ready_o/r_last_o are 0 the next cycle and the FSM is in IDLE.
- Write: w_valid_i sampled in IDLE at T drives w_ready_o=1 from cycle T+1. With continuous w_valid_i, beat k commits at T+1+k. w_ready_o=0 the cycle after w_last_o.
- Read-after-write to the same word returns the new data. No new request is accepted in the cycle a transaction finishes; the earliest acceptance is the following IDLE cycle.
- Reset mid-burst: outputs go to reset values at the next edge and the transaction is abandoned. Beats already committed stay written.
- r_data_o is 0 whenever r_ready_o=0.

## Test plan
- Single write then read: write addr 0x8000_0008, len 0, size 3, data 0x1122334455667788. Then read addr 0x8000_0008, len 0, RD_LAT=2. Required: r_ready_o=r_last_o=1 exactly 3 cycles after acceptance, data 0x1122334455667788.
- Byte masking: preload 0xFFFF_FFFF_FFFF_FFFF at 0x8000_0010. Write addr 0x8000_0013, size 1, data 0xABCD. Required: readback 0xFFFF_FFAB_CDFF_FFFF.
- 2-beat burst, cache-line style: write 0x8000_0100, len 1, data 0xA then 0xB; read the line back. Required: w_last_o on beat 1 only; read beats 0xA then 0xB on consecutive cycles, r_last_o on the second.
- Simultaneous r_valid_i and w_valid_i in IDLE to the same word: the write completes first, then the read returns the written value.
- Out of range: read 0x1000_0000, len 0. Required: data 0, err_cnt_o=1. Burst write, len 1, starting at the last word: beat 0 written, beat 1 dropped, err_cnt_o=2.
- Reset asserted during read beat 0 of a 4-beat burst. Required: next cycle all outputs 0. A new read issued after reset returns correct data.
